// File: rtl/avalon16_wb32.sv
// rtl/avalon16_wb32.sv - Avalon-MM 16-bit slave to Wishbone 32-bit classic master bridge
// One Wishbone cycle per accepted halfword access; a one-word buffer serves the sibling halfword of the last read.
module avalon16_wb32 #(
    parameter int          AW             = 22,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CACHE_EN       = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] avalon_address_i,
    input  logic [1:0]    avalon_byteenable_n_i,
    input  logic          avalon_chipselect_i,
    input  logic          avalon_read_n_i,
    input  logic          avalon_write_n_i,
    input  logic [15:0]   avalon_writedata_i,
    output logic [15:0]   avalon_readdata_o,
    output logic          avalon_waitrequest_o,
    output logic          avalon_readdatavalid_o,
    output logic [31:0]   wishbone_addr_o,
    output logic [31:0]   wishbone_data_o,
    output logic [3:0]    wishbone_sel_o,
    output logic          wishbone_we_o,
    output logic          wishbone_cyc_o,
    output logic          wishbone_stb_o,
    input  logic [31:0]   wishbone_data_i,
    input  logic          wishbone_ack_i,
    input  logic          wishbone_err_i,
    output logic          bus_error_o
);

    typedef enum logic [1:0] {IDLE, WB_WRITE, WB_READ} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          cyc_q;
    logic [15:0]   rdata_q;
    logic          rdv_q;
    logic          err_q;
    logic [7:0]    cnt_q;
    logic          half_q;
    logic [AW-2:0] wa_q;
    logic          buf_v_q;
    logic [AW-2:0] buf_tag_q;
    logic [31:0]   buf_q;

    logic [AW-2:0] wa;
    logic          h;
    logic          req_wr;
    logic          req_rd;
    logic          hit;
    logic [31:0]   wb_addr;
    logic [3:0]    lanes;
    logic          timeout;
    logic          finish;
    logic          fail;

    assign wa      = avalon_address_i[AW-1:1];
    assign h       = avalon_address_i[0];
    assign req_wr  = avalon_chipselect_i & ~avalon_write_n_i;
    assign req_rd  = avalon_chipselect_i & ~avalon_read_n_i & avalon_write_n_i;
    assign hit     = (CACHE_EN != 0) && buf_v_q && (buf_tag_q == wa);
    assign wb_addr = BASE_ADDR + {{(32-AW-1){1'b0}}, wa, 2'b00};
    assign lanes   = h ? {~avalon_byteenable_n_i, 2'b00} : {2'b00, ~avalon_byteenable_n_i};

    // err beats ack; the timeout only counts as a failure when no ack arrived that cycle
    assign timeout = (cnt_q == TO_LAST);
    assign finish  = wishbone_ack_i | wishbone_err_i | timeout;
    assign fail    = wishbone_err_i | (timeout & ~wishbone_ack_i);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            half_q    <= 1'b0;
            wa_q      <= '0;
            buf_v_q   <= 1'b0;
            buf_tag_q <= '0;
            buf_q     <= '0;
        end else begin
            rdv_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req_wr) begin
                        if (buf_v_q && (buf_tag_q == wa)) begin
                            buf_v_q <= 1'b0;
                        end
                        if (avalon_byteenable_n_i != 2'b11) begin
                            addr_q  <= wb_addr;
                            wdata_q <= {avalon_writedata_i, avalon_writedata_i};
                            sel_q   <= lanes;
                            we_q    <= 1'b1;
                            cyc_q   <= 1'b1;
                            state_q <= WB_WRITE;
                        end
                    end else if (req_rd) begin
                        if (hit) begin
                            rdv_q   <= 1'b1;
                            rdata_q <= h ? buf_q[31:16] : buf_q[15:0];
                        end else begin
                            addr_q  <= wb_addr;
                            sel_q   <= 4'hF;
                            we_q    <= 1'b0;
                            cyc_q   <= 1'b1;
                            half_q  <= h;
                            wa_q    <= wa;
                            state_q <= WB_READ;
                        end
                    end
                end
                default: begin
                    if (finish) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= fail;
                        state_q <= IDLE;
                        if (state_q == WB_READ) begin
                            rdv_q <= 1'b1;
                            if (fail) begin
                                rdata_q <= '0;
                                buf_v_q <= 1'b0;
                            end else begin
                                rdata_q   <= half_q ? wishbone_data_i[31:16] : wishbone_data_i[15:0];
                                buf_q     <= wishbone_data_i;
                                buf_tag_q <= wa_q;
                                buf_v_q   <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign avalon_waitrequest_o   = (state_q != IDLE);
    assign avalon_readdata_o      = rdata_q;
    assign avalon_readdatavalid_o = rdv_q;
    assign wishbone_addr_o        = addr_q;
    assign wishbone_data_o        = wdata_q;
    assign wishbone_sel_o         = sel_q;
    assign wishbone_we_o          = we_q;
    assign wishbone_cyc_o         = cyc_q;
    assign wishbone_stb_o         = cyc_q;
    assign bus_error_o            = err_q;

endmodule

// File: tb/tb_avalon16_wb32.sv
// tb/tb_avalon16_wb32.sv - self-checking bench for avalon16_wb32
// Transaction-level model of the bridge plus a per-cycle protocol checker on the falling edge.
module tb_avalon16_wb32;

    localparam int          AW   = 22;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] av_addr = '0;
    logic [1:0]    av_be_n = 2'b11;
    logic          av_cs = 1'b0;
    logic          av_read_n = 1'b1;
    logic          av_write_n = 1'b1;
    logic [15:0]   av_wdata = '0;
    logic [15:0]   av_rdata;
    logic          av_wait;
    logic          av_rdv;
    logic [31:0]   wb_addr;
    logic [31:0]   wb_dout;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;
    logic [31:0]   wb_rdata = '0;
    logic          wb_ack = 1'b0;
    logic          wb_err = 1'b0;
    logic          bus_err;

    always #5 clk = ~clk;

    avalon16_wb32 #(
        .AW(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO), .CACHE_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avalon_address_i(av_addr), .avalon_byteenable_n_i(av_be_n),
        .avalon_chipselect_i(av_cs), .avalon_read_n_i(av_read_n),
        .avalon_write_n_i(av_write_n), .avalon_writedata_i(av_wdata),
        .avalon_readdata_o(av_rdata), .avalon_waitrequest_o(av_wait),
        .avalon_readdatavalid_o(av_rdv),
        .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_dout),
        .wishbone_sel_o(wb_sel), .wishbone_we_o(wb_we),
        .wishbone_cyc_o(wb_cyc), .wishbone_stb_o(wb_stb),
        .wishbone_data_i(wb_rdata), .wishbone_ack_i(wb_ack),
        .wishbone_err_i(wb_err), .bus_error_o(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_bus[$];
    logic [15:0] exp_rd[$];
    int          total = 0;
    int          bad = 0;

    // model of the read buffer
    logic          m_v = 1'b0;
    logic [AW-2:0] m_tag = '0;
    logic [31:0]   m_d = '0;

    // slave behaviour: 0 ack, 1 err, 2 never respond, 3 ack and err together
    int wb_mode = 0;
    int wb_delay = 1;
    int wcnt = 0;

    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [15:0] cap_rd;
    int          busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_addr(input logic [AW-1:0] a);
        return BASE + 32'(a / 2) * 32'd4;
    endfunction

    function automatic logic [3:0] m_sel(input logic [AW-1:0] a, input logic [1:0] be_n);
        logic [3:0] l;
        l = {2'b00, ~be_n};
        return a[0] ? (l << 2) : l;
    endfunction

    function automatic logic [15:0] m_half(input logic [31:0] d, input logic h);
        return 16'(d >> (h ? 16 : 0));
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc && wb_stb) begin
                wcnt++;
                if (wb_mode != 2 && wcnt == wb_delay) begin
                    wb_ack = (wb_mode == 0 || wb_mode == 3);
                    wb_err = (wb_mode == 1 || wb_mode == 3);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // per-cycle checker: cycle framing, timeout length, error pulse, queued bus/read expectations
    initial begin
        logic prev_cyc, term_pend, err_pend, rst_pend;
        int   cyc_cnt;
        bus_t e;
        prev_cyc = 0; term_pend = 0; err_pend = 0; rst_pend = 0; cyc_cnt = 0;
        forever begin
            @(negedge clk);
            chk("wait_eq_cyc", av_wait, wb_cyc);
            chk("stb_eq_cyc", wb_stb, wb_cyc);
            if (rst_pend) begin
                chk("rst_cyc", wb_cyc, 0);
                chk("rst_rdv", av_rdv, 0);
                chk("rst_buserr", bus_err, 0);
            end else begin
                if (term_pend) chk("cyc_drop", wb_cyc, 0);
                else if (prev_cyc) chk("cyc_hold", wb_cyc, 1);
                chk("bus_error", bus_err, err_pend);
                if (wb_cyc && !prev_cyc) begin
                    if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
                    else begin
                        e = exp_bus.pop_front();
                        chk("bus_addr", wb_addr, e.addr);
                        chk("bus_sel", wb_sel, e.sel);
                        chk("bus_we", wb_we, e.we);
                        if (e.we) chk("bus_data", wb_dout, e.data);
                    end
                end
                if (av_rdv) begin
                    if (exp_rd.size() == 0) chk("rdv_unexpected", 1, 0);
                    else chk("rd_data", av_rdata, exp_rd.pop_front());
                end
            end
            cyc_cnt   = wb_cyc ? cyc_cnt + 1 : 0;
            term_pend = wb_cyc && (wb_ack || wb_err || cyc_cnt == TO);
            err_pend  = wb_cyc && (wb_err || (!wb_ack && cyc_cnt == TO));
            prev_cyc  = wb_cyc;
            rst_pend  = !reset_n;
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (av_wait && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (av_wait) chk("idle_timeout", 1, 0);
    endtask

    task automatic av_issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [1:0] be, input logic [15:0] wd);
        @(posedge clk); #1;
        av_cs = 1'b1; av_read_n = !rd; av_write_n = !wr;
        av_addr = a; av_be_n = be; av_wdata = wd;
        @(posedge clk); #1;
        av_cs = 1'b0; av_read_n = 1'b1; av_write_n = 1'b1;
        cap_addr = wb_addr; cap_sel = wb_sel; cap_we = wb_we; cap_data = wb_dout;
    endtask

    task automatic do_write(input logic also_rd, input logic [AW-1:0] a,
                            input logic [1:0] be, input logic [15:0] d, output int n);
        int dummy;
        wait_idle(dummy);
        if (be != 2'b11) exp_bus.push_back('{m_addr(a), m_sel(a, be), 1'b1, {d, d}});
        if (m_v && m_tag == a[AW-1:1]) m_v = 1'b0;
        av_issue(also_rd, 1'b1, a, be, d);
        chk("wr_cyc_c1", wb_cyc, (be != 2'b11));
        wait_idle(n);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int n);
        logic hit;
        int   dummy;
        wait_idle(dummy);
        hit = m_v && (m_tag == a[AW-1:1]);
        if (hit) begin
            exp_rd.push_back(m_half(m_d, a[0]));
        end else begin
            exp_bus.push_back('{m_addr(a), 4'hF, 1'b0, 32'h0});
            if (wb_mode == 0) begin
                exp_rd.push_back(m_half(wb_rdata, a[0]));
                m_v = 1'b1; m_tag = a[AW-1:1]; m_d = wb_rdata;
            end else begin
                exp_rd.push_back(16'h0000);
                m_v = 1'b0;
            end
        end
        av_issue(1'b1, 1'b0, a, 2'b11, 16'h0);
        chk("rd_rdv_c1", av_rdv, hit);
        chk("rd_cyc_c1", wb_cyc, !hit);
        cap_rd = av_rdata;
        wait_idle(n);
        if (!hit) begin
            chk("miss_rdv_at_idle", av_rdv, 1);
            cap_rd = av_rdata;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait", av_wait, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_dout", wb_dout, 0);
        chk("rst_sel", wb_sel, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_cyc_lit", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_rdata", av_rdata, 0);
        chk("rst_rdv_lit", av_rdv, 0);
        chk("rst_buserr_lit", bus_err, 0);
        reset_n = 1'b1;

        // write to upper half, ack after 3 cycles
        wb_mode = 0; wb_delay = 3;
        do_write(1'b0, 22'h000003, 2'b00, 16'hBEEF, busy);
        chk("w1_addr", cap_addr, 32'h4);
        chk("w1_sel", cap_sel, 4'hC);
        chk("w1_data", cap_data, 32'hBEEFBEEF);
        chk("w1_we", cap_we, 1);
        chk("w1_busy", busy, 3);
        chk("w1_cyc_after", wb_cyc, 0);

        // miss then sibling hit
        wb_delay = 1; wb_rdata = 32'h12345678;
        do_read(22'h000010, busy);
        chk("r1_data", cap_rd, 16'h5678);
        chk("r1_busy", busy, 1);
        do_read(22'h000011, busy);
        chk("r2_data", cap_rd, 16'h1234);
        chk("r2_busy", busy, 0);

        // write to buffered word invalidates it
        wb_delay = 2;
        do_write(1'b0, 22'h000011, 2'b01, 16'h00AA, busy);
        chk("w2_sel", cap_sel, 4'h8);
        chk("w2_data", cap_data, 32'h00AA00AA);
        wb_rdata = 32'h00AA5678;
        do_read(22'h000011, busy);
        chk("r3_data", cap_rd, 16'h00AA);

        // timeout then re-read of the same word goes to the bus
        wb_mode = 2;
        do_read(22'h000020, busy);
        chk("to_busy", busy, TO);
        chk("to_buserr", bus_err, 1);
        chk("to_data", cap_rd, 16'h0000);
        wb_mode = 0; wb_delay = 1; wb_rdata = 32'hCAFEF00D;
        do_read(22'h000020, busy);
        chk("to_reread", cap_rd, 16'hF00D);

        // err, and ack+err together, on reads and a write
        wb_mode = 3; wb_delay = 2;
        do_read(22'h000031, busy);
        chk("ae_data", cap_rd, 16'h0000);
        chk("ae_buserr", bus_err, 1);
        wb_mode = 1;
        do_write(1'b0, 22'h000032, 2'b00, 16'h1111, busy);
        chk("we_buserr", bus_err, 1);

        // simultaneous read+write, then a write with no byte enables
        wb_mode = 0; wb_delay = 1;
        do_write(1'b1, 22'h000040, 2'b10, 16'h5A5A, busy);
        chk("rw_sel", cap_sel, 4'h1);
        chk("rw_we", cap_we, 1);
        do_write(1'b0, 22'h000041, 2'b11, 16'h7777, busy);
        chk("be11_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("be11_wait", av_wait, 0);
        end

        // reset while a read is outstanding drops it and clears the buffer
        wb_rdata = 32'h9999AAAA;
        do_read(22'h000050, busy);
        wb_mode = 2;
        wait_idle(busy);
        exp_bus.push_back('{m_addr(22'h000060), 4'hF, 1'b0, 32'h0});
        av_issue(1'b1, 1'b0, 22'h000060, 2'b00, 16'h0);
        repeat (2) begin @(posedge clk); #1; end
        chk("mr_cyc_before", wb_cyc, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_v = 1'b0;
        chk("mr_cyc", wb_cyc, 0);
        chk("mr_stb", wb_stb, 0);
        chk("mr_wait", av_wait, 0);
        chk("mr_rdv", av_rdv, 0);
        wb_mode = 0; wb_rdata = 32'h3333BBBB;
        do_read(22'h000051, busy);
        chk("mr_reread", cap_rd, 16'h3333);

        repeat (4) @(posedge clk);
        #1;
        chk("bus_q_empty", exp_bus.size(), 0);
        chk("rd_q_empty", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
